// File: rtl/set_assoc_cache_if.sv
// CPU load-path and refill-memory signals of the 2-way set-associative read cache.
// The master side is the requester/backing memory; the slave side is the cache.
interface set_assoc_cache_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output cpu_req, cpu_addr, flush, mem_rvalid, mem_rdata,
    input  cpu_rdata, cpu_ready, mem_req, mem_addr
  );

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_rvalid, mem_rdata,
    output cpu_rdata, cpu_ready, mem_req, mem_addr
  );
endinterface

// File: rtl/set_assoc_cache.sv
// 2-way set-associative read cache with per-set LRU, multi-word blocks and burst refill.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
//
// state  | meaning
// IDLE   | waiting for a request or flush
// LOOKUP | tag compare on the array read launched in the previous cycle
// REFILL | mem_req high, writing refill beats into the victim way
// REREAD | re-reading the arrays for the latched address after a refill
module set_assoc_cache #(
  parameter int SETS_LOG2  = 10,
  parameter int WORDS_LOG2 = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  set_assoc_cache_if.slave   bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);
  localparam int SETS   = 1 << SETS_LOG2;
  localparam int WORDS  = 1 << WORDS_LOG2;
  localparam int TAG_W  = 30 - SETS_LOG2 - WORDS_LOG2;
  localparam int LINE_W = SETS_LOG2 + WORDS_LOG2;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, REREAD} state_t;
  state_t state_q, state_d;

  logic [31:2]           addr_q;
  logic [SETS-1:0]       valid0, valid1, lru;
  logic                  victim_q;
  logic [WORDS_LOG2-1:0] beat_q;
  logic [31:0]           mem_addr_q;

  logic [31:0]           data0 [SETS*WORDS];
  logic [31:0]           data1 [SETS*WORDS];
  logic [TAG_W-1:0]      tags0 [SETS];
  logic [TAG_W-1:0]      tags1 [SETS];
  logic [31:0]           word0, word1;
  logic [TAG_W-1:0]      tag0_rd, tag1_rd;

  logic [TAG_W-1:0]      tag_q;
  logic [SETS_LOG2-1:0]  idx_q, rd_idx;
  logic [LINE_W-1:0]     rd_line;
  logic                  hit0, hit1, hit, victim, last_beat, accept;
  logic                  rd_en, beat_we, tag_we, cpu_ready, mem_req;
  logic [31:0]           cpu_rdata;

  assign tag_q     = addr_q[31 -: TAG_W];
  assign idx_q     = addr_q[LINE_W+1:WORDS_LOG2+2];
  assign rd_line   = (state_q == IDLE) ? bus.cpu_addr[LINE_W+1:2] : addr_q[LINE_W+1:2];
  assign rd_idx    = rd_line[LINE_W-1:WORDS_LOG2];
  assign hit0      = valid0[idx_q] && (tag0_rd == tag_q);
  assign hit1      = valid1[idx_q] && (tag1_rd == tag_q);
  assign hit       = hit0 || hit1;
  assign victim    = !valid0[idx_q] ? 1'b0 : (!valid1[idx_q] ? 1'b1 : lru[idx_q]);
  assign last_beat = (beat_q == '1);
  assign accept    = (state_q == IDLE) && !bus.flush && bus.cpu_req;

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    rd_en     = 1'b0;
    beat_we   = 1'b0;
    tag_we    = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        rd_en   = 1'b1;
        state_d = LOOKUP;
      end
      LOOKUP: if (hit) begin
        cpu_ready = 1'b1;
        cpu_rdata = hit1 ? word1 : word0;
        state_d   = IDLE;
      end else begin
        state_d = REFILL;
      end
      REFILL: begin
        mem_req = 1'b1;
        if (bus.mem_rvalid) begin
          beat_we = 1'b1;
          if (last_beat) begin
            tag_we  = 1'b1;
            state_d = REREAD;
          end
        end
      end
      REREAD: begin
        rd_en   = 1'b1;
        state_d = LOOKUP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Arrays are plain synchronous RAMs; writes are gated so a reset cycle never lands a beat.
  always_ff @(posedge CLK) begin
    if (rd_en) begin
      word0   <= data0[rd_line];
      word1   <= data1[rd_line];
      tag0_rd <= tags0[rd_idx];
      tag1_rd <= tags1[rd_idx];
    end
    if (RST_N && beat_we) begin
      if (victim_q) data1[{idx_q, beat_q}] <= bus.mem_rdata;
      else          data0[{idx_q, beat_q}] <= bus.mem_rdata;
    end
    if (RST_N && tag_we) begin
      if (victim_q) tags1[idx_q] <= tag_q;
      else          tags0[idx_q] <= tag_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      valid0     <= '0;
      valid1     <= '0;
      lru        <= '0;
      addr_q     <= '0;
      victim_q   <= 1'b0;
      beat_q     <= '0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.flush) begin
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
          end else if (bus.cpu_req) begin
            addr_q <= bus.cpu_addr[31:2];
          end
        end
        LOOKUP: begin
          if (hit0) lru[idx_q] <= 1'b1;
          else if (hit1) lru[idx_q] <= 1'b0;
          else begin
            victim_q   <= victim;
            beat_q     <= '0;
            mem_addr_q <= {tag_q, idx_q, {(WORDS_LOG2+2){1'b0}}};
            if (victim) valid1[idx_q] <= 1'b0;
            else        valid0[idx_q] <= 1'b0;
          end
        end
        REFILL: begin
          if (bus.mem_rvalid) begin
            beat_q <= beat_q + 1'b1;
            if (last_beat) begin
              lru[idx_q] <= ~victim_q;
              if (victim_q) valid1[idx_q] <= 1'b1;
              else          valid0[idx_q] <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // first_q marks the lookup of a freshly accepted request; the post-refill lookup is not counted.
  logic first_q;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      first_q    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (accept) first_q <= 1'b1;
      else if (state_q == LOOKUP) first_q <= 1'b0;
      if (state_q == LOOKUP && first_q) begin
        if (hit) hit_count  <= hit_count + 32'd1;
        else     miss_count <= miss_count + 32'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

  assign bus.cpu_ready = cpu_ready;
  assign bus.cpu_rdata = cpu_rdata;
  assign bus.mem_req   = mem_req;
  assign bus.mem_addr  = mem_addr_q;
endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: directed vector table, flush / reset / gap sequences,
// and random reads checked against an LRU-ordered per-set model of resident blocks.
module tb_set_assoc_cache;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  set_assoc_cache_if bus();
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  set_assoc_cache dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  int gen = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  // Model: per set, up to two resident blocks; index 0 is least recently used.
  int          m_n   [1024];
  logic [31:0] m_blk [1024][2];
  int          m_gen [1024][2];

  typedef struct {
    logic [31:0] addr;
    int          gap;
    bit          exp_miss;
    logic [31:0] exp_maddr;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a, input int g);
    logic [31:0] gg;
    gg = g;
    if (g == 0 && a[31:4] == 28'h100) return 32'hA0 + {28'd0, a[3:2]};
    return (a ^ 32'hC0DE_0000) + gg * 32'h0101_0101;
  endfunction

  task automatic m_clear();
    for (int s = 0; s < 1024; s++) m_n[s] = 0;
  endtask

  task automatic m_access(input logic [31:0] a, output bit hit, output int g);
    int s;
    logic [31:0] b;
    logic [31:0] tb;
    int tg;
    s = int'(a[13:4]);
    b = a & 32'hFFFF_FFF0;
    hit = 0;
    g = gen;
    for (int p = 0; p < m_n[s]; p++) begin
      if (!hit && m_blk[s][p] == b) begin
        hit = 1;
        g = m_gen[s][p];
        if (p == 0 && m_n[s] == 2) begin
          tb = m_blk[s][0]; tg = m_gen[s][0];
          m_blk[s][0] = m_blk[s][1]; m_gen[s][0] = m_gen[s][1];
          m_blk[s][1] = tb; m_gen[s][1] = tg;
        end
      end
    end
    if (!hit) begin
      if (m_n[s] == 2) begin
        m_blk[s][0] = m_blk[s][1]; m_gen[s][0] = m_gen[s][1];
        m_n[s] = 1;
      end
      m_blk[s][m_n[s]] = b;
      m_gen[s][m_n[s]] = gen;
      m_n[s]++;
    end
  endtask

  // Starts at a negedge in IDLE, returns at a negedge in IDLE.
  task automatic do_read(input logic [31:0] a, input int gap, output logic [31:0] data,
                         output int lat, output bit miss, output logic [31:0] maddr, output int rcyc);
    int beat, idle;
    bit done;
    data = '0; lat = 0; miss = 0; maddr = '0; rcyc = 0; beat = 0; idle = 0; done = 0;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = a;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      lat++;
      bus.cpu_addr = $urandom & 32'hFFFF_FFFC;
      if (bus.cpu_ready) begin
        data = bus.cpu_rdata;
        done = 1;
        bus.cpu_req = 1'b0;
        bus.mem_rvalid = 1'b0;
      end else if (bus.mem_req) begin
        if (miss) chk("mem_addr_stable", bus.mem_addr, maddr);
        else maddr = bus.mem_addr;
        miss = 1;
        rcyc++;
        if (beat < 4 && idle >= gap) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata = mem_data(maddr + 32'(4 * beat), gen);
          beat++;
          idle = 0;
        end else begin
          bus.mem_rvalid = 1'b0;
          bus.mem_rdata = $urandom;
          idle++;
        end
      end else begin
        bus.mem_rvalid = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
      end
    end
    chk("read_done", 32'(done), 32'd1);
    bus.cpu_req = 1'b0;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_op(input logic [31:0] a, input int gap, output bit miss,
                        output logic [31:0] data, output logic [31:0] maddr);
    bit exp_hit;
    int g, lat, rcyc;
    m_access(a, exp_hit, g);
    if (exp_hit) exp_hits++; else exp_misses++;
    do_read(a, gap, data, lat, miss, maddr, rcyc);
    chk("model_miss", 32'(miss), 32'(!exp_hit));
    chk("model_data", data, mem_data(a, g));
    chk("model_latency", 32'(lat), exp_hit ? 32'd1 : 32'(7 + 4 * gap));
    if (!exp_hit) begin
      chk("model_maddr", maddr, a & 32'hFFFF_FFF0);
      chk("refill_cycles", 32'(rcyc), 32'(4 * (gap + 1)));
    end
  endtask

  // A request is held alongside the flush to show flush wins that cycle.
  task automatic flush_pulse(input logic [31:0] a);
    bus.flush = 1'b1;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = a;
    @(negedge clk);
    chk("flush_no_ready", 32'(bus.cpu_ready), 32'd0);
    bus.flush = 1'b0;
    m_clear();
  endtask

  initial begin
    bit miss;
    logic [31:0] data, maddr;

    vecs[0]  = '{32'h1004, 0, 1, 32'h1000, 32'hA1};
    vecs[1]  = '{32'h1008, 0, 0, 32'h0,    32'hA2};
    vecs[2]  = '{32'h5000, 0, 1, 32'h5000, mem_data(32'h5000, 0)};
    vecs[3]  = '{32'h1000, 1, 0, 32'h0,    32'hA0};
    vecs[4]  = '{32'h9000, 0, 1, 32'h9000, mem_data(32'h9000, 0)};
    vecs[5]  = '{32'h1000, 0, 0, 32'h0,    32'hA0};
    vecs[6]  = '{32'h5004, 2, 1, 32'h5000, mem_data(32'h5004, 0)};
    vecs[7]  = '{32'h100C, 0, 0, 32'h0,    32'hA3};
    vecs[8]  = '{32'h2000, 3, 1, 32'h2000, mem_data(32'h2000, 0)};
    vecs[9]  = '{32'h2004, 0, 0, 32'h0,    mem_data(32'h2004, 0)};
    vecs[10] = '{32'h2008, 0, 0, 32'h0,    mem_data(32'h2008, 0)};
    vecs[11] = '{32'h200C, 0, 0, 32'h0,    mem_data(32'h200C, 0)};

    rst_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.flush = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    m_clear();
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
`ifdef CACHE_STATS_EN
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].addr, vecs[i].gap, miss, data, maddr);
      chk($sformatf("vec%0d_miss", i), 32'(miss), 32'(vecs[i].exp_miss));
      chk($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      if (vecs[i].exp_miss) chk($sformatf("vec%0d_maddr", i), maddr, vecs[i].exp_maddr);
`ifdef CACHE_STATS_EN
      if (i == 1) begin
        chk("stats_hit_first", hit_count, 32'd1);
        chk("stats_miss_first", miss_count, 32'd1);
      end
`endif
    end

    flush_pulse(32'h1000);
    run_op(32'h1000, 0, miss, data, maddr);
    chk("flush_then_miss", 32'(miss), 32'd1);
    chk("flush_maddr", maddr, 32'h1000);

    // Reset after two of four beats of a refill.
    flush_pulse(32'h1000);
    @(negedge clk);
    chk("rst_mid_lookup_memreq", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    chk("rst_mid_refill_memreq", 32'(bus.mem_req), 32'd1);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = mem_data(32'h1000, gen);
    @(negedge clk);
    bus.mem_rdata = mem_data(32'h1004, gen);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_memreq_low", 32'(bus.mem_req), 32'd0);
    chk("rst_mid_mem_addr", bus.mem_addr, 32'd0);
    bus.cpu_req = 1'b0;
    rst_n = 1'b1;
    m_clear();
    exp_hits = 0; exp_misses = 0;
    gen++;
    run_op(32'h1000, 0, miss, data, maddr);
    chk("post_rst_miss", 32'(miss), 32'd1);
    chk("post_rst_new_data", data, mem_data(32'h1000, 1));

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      int s_sel;
      s_sel = $urandom_range(0, 2);
      a = ({30'd0, 2'($urandom_range(0, 3))} << 14)
        | ({22'd0, (s_sel == 0) ? 10'h100 : (s_sel == 1) ? 10'h003 : 10'h3FF} << 4)
        | ({30'd0, 2'($urandom_range(0, 3))} << 2);
      if ($urandom_range(0, 15) == 0) flush_pulse(a);
      run_op(a, $urandom_range(0, 2), miss, data, maddr);
    end

`ifdef CACHE_STATS_EN
    chk("end_hit_count", hit_count, 32'(exp_hits));
    chk("end_miss_count", miss_count, 32'(exp_misses));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
